// File: rtl/vm_pkg.sv
// Shared definitions for the N-candidate voting controller.
//   vm_state_e : externally visible state encoding (IDLE/OPEN/ARMED/RESULT)
//   MAX_CAND   : largest supported candidate count
//   WIN_W      : width of the winner index
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_ARMED  = 2'b10,
        ST_RESULT = 2'b11
    } vm_state_e;

    localparam int unsigned MAX_CAND = 8;
    localparam int unsigned WIN_W    = 3;

endpackage

// File: rtl/vm_winner_scan.sv
// Sequential winner scan: visits one candidate per cycle after start.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : drop any scan in progress and zero the results
//   start       : one-cycle pulse, begins a scan from candidate 0
//   counts      : packed per-candidate counters, candidate i at [i*CNT_W +: CNT_W]
//   winner, tie : result, published together with valid
//   valid       : scan finished; winner/tie hold until clear/start
module vm_winner_scan
    import vm_pkg::*;
#(
    parameter int unsigned NUM_CAND = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      start,
    input  logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [WIN_W-1:0]          winner,
    output logic                      tie,
    output logic                      valid
);

    localparam logic [WIN_W-1:0] LAST = WIN_W'(NUM_CAND - 1);

    logic [WIN_W-1:0] idx;
    logic             busy;
    logic [CNT_W-1:0] max_q;
    logic [WIN_W-1:0] win_q;
    logic             tie_q;
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] nx_max;
    logic [WIN_W-1:0] nx_win;
    logic             nx_tie;

    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (idx == WIN_W'(i)) cur = counts[i*CNT_W +: CNT_W];
        end
    end

    // Candidate 0 seeds the running maximum; later equal counts keep the
    // lower index and flag a tie, a strictly larger one clears the tie.
    always_comb begin
        nx_max = max_q;
        nx_win = win_q;
        nx_tie = tie_q;
        if (idx == '0) begin
            nx_max = cur;
            nx_win = '0;
            nx_tie = 1'b0;
        end else if (cur > max_q) begin
            nx_max = cur;
            nx_win = idx;
            nx_tie = 1'b0;
        end else if (cur == max_q) begin
            nx_tie = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx    <= '0;
            busy   <= 1'b0;
            max_q  <= '0;
            win_q  <= '0;
            tie_q  <= 1'b0;
            winner <= '0;
            tie    <= 1'b0;
            valid  <= 1'b0;
        end else if (start) begin
            idx    <= '0;
            busy   <= 1'b1;
            winner <= '0;
            tie    <= 1'b0;
            valid  <= 1'b0;
        end else if (busy) begin
            max_q <= nx_max;
            win_q <= nx_win;
            tie_q <= nx_tie;
            if (idx == LAST) begin
                busy   <= 1'b0;
                valid  <= 1'b1;
                winner <= nx_win;
                tie    <= nx_tie;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voting_machine_n.sv
// Parametrised N-candidate voting controller.
// Optional feature macro: VOTER_AUTH_EN (voter_ok arms a single vote with
// an ARM_TIMEOUT-cycle window; undefined = votes accepted directly in OPEN).
// Ports:
//   clk_100MHz, reset : clock, synchronous active-high reset
//   code              : access code switches, checked on btn_oc rise
//   btn_oc            : open/close button level
//   vote_btn          : candidate button levels, bit i = candidate i
//   voter_ok          : fingerprint-match pulse
//   state             : 00 IDLE, 01 OPEN, 10 ARMED, 11 RESULT
//   enable_led        : high in OPEN/ARMED
//   cand_count        : packed saturating counters, candidate i at [i*CNT_W +: CNT_W]
//   vote_count        : saturating total of accepted votes
//   winner, tie       : scan result, qualified by result_valid
//   vote_ack/vote_nak : one-cycle accept/reject pulses
//   code_err          : one-cycle pulse, btn_oc rose with a wrong code
module voting_machine_n
    import vm_pkg::*;
#(
    parameter int unsigned       NUM_CAND    = 3,
    parameter int unsigned       CNT_W       = 8,
    parameter int unsigned       CODE_W      = 16,
    parameter logic [CODE_W-1:0] OPEN_CODE   = 16'hA5C3,
    parameter int unsigned       ARM_TIMEOUT = 1000
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic [CODE_W-1:0]         code,
    input  logic                      btn_oc,
    input  logic [NUM_CAND-1:0]       vote_btn,
    input  logic                      voter_ok,
    output logic [1:0]                state,
    output logic                      enable_led,
    output logic [NUM_CAND*CNT_W-1:0] cand_count,
    output logic [CNT_W-1:0]          vote_count,
    output logic [WIN_W-1:0]          winner,
    output logic                      tie,
    output logic                      result_valid,
    output logic                      vote_ack,
    output logic                      vote_nak,
    output logic                      code_err
);

    vm_state_e st_q, st_d;

    logic                      oc_q, oc_rise;
    logic [NUM_CAND-1:0]       vb_q, vb_rise;
    logic [NUM_CAND*CNT_W-1:0] cand_q;
    logic [CNT_W-1:0]          vote_q;
    logic [NUM_CAND-1:0]       sat_vec;
    logic                      any_edge, vote_ok;
    logic                      ack_q, nak_q, err_q, scan_start_q;
    logic                      ack_d, nak_d, err_d, cnt_en, clr_d, scan_d;

    // Registered edge detectors: the rise pulses are themselves flops.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            oc_q    <= 1'b0;
            oc_rise <= 1'b0;
            vb_q    <= '0;
            vb_rise <= '0;
        end else begin
            oc_q    <= btn_oc;
            oc_rise <= btn_oc & ~oc_q;
            vb_q    <= vote_btn;
            vb_rise <= vote_btn & ~vb_q;
        end
    end

    always_comb begin
        sat_vec = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            sat_vec[i] = &cand_q[i*CNT_W +: CNT_W];
        end
    end

    assign any_edge = |vb_rise;
    assign vote_ok  = $onehot(vb_rise) && !(|(vb_rise & sat_vec)) && !(&vote_q);

`ifdef VOTER_AUTH_EN
    localparam int unsigned TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr_q;
    logic             arm_d;
    logic             tmr_zero;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tmr_q <= '0;
        end else if (arm_d) begin
            tmr_q <= TMR_W'(ARM_TIMEOUT - 1);
        end else if (st_q == ST_ARMED && tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    assign tmr_zero = (tmr_q == '0);
`else
    logic unused_auth;
    assign unused_auth = voter_ok | (ARM_TIMEOUT == 0);
`endif

    always_comb begin
        st_d   = st_q;
        ack_d  = 1'b0;
        nak_d  = 1'b0;
        err_d  = 1'b0;
        cnt_en = 1'b0;
        clr_d  = 1'b0;
        scan_d = 1'b0;
`ifdef VOTER_AUTH_EN
        arm_d  = 1'b0;
`endif
        if (oc_rise) begin
            // btn_oc wins over any vote edge in the same cycle; the vote is dropped.
            if (code != OPEN_CODE) begin
                err_d = 1'b1;
            end else begin
                case (st_q)
                    ST_IDLE:   st_d = ST_OPEN;
                    ST_OPEN,
                    ST_ARMED: begin
                        st_d   = ST_RESULT;
                        scan_d = 1'b1;
                    end
                    ST_RESULT: begin
                        st_d  = ST_IDLE;
                        clr_d = 1'b1;
                    end
                    default:   st_d = ST_IDLE;
                endcase
            end
        end else begin
            case (st_q)
                ST_OPEN: begin
`ifdef VOTER_AUTH_EN
                    if (any_edge) begin
                        nak_d = 1'b1;
                    end else if (voter_ok) begin
                        st_d  = ST_ARMED;
                        arm_d = 1'b1;
                    end
`else
                    if (any_edge) begin
                        if (vote_ok) begin
                            cnt_en = 1'b1;
                            ack_d  = 1'b1;
                        end else begin
                            nak_d = 1'b1;
                        end
                    end
`endif
                end
                ST_ARMED: begin
`ifdef VOTER_AUTH_EN
                    if (any_edge) begin
                        st_d = ST_OPEN;
                        if (vote_ok) begin
                            cnt_en = 1'b1;
                            ack_d  = 1'b1;
                        end else begin
                            nak_d = 1'b1;
                        end
                    end else if (tmr_zero) begin
                        st_d = ST_OPEN;
                    end
`else
                    st_d = ST_OPEN;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            st_q         <= ST_IDLE;
            cand_q       <= '0;
            vote_q       <= '0;
            ack_q        <= 1'b0;
            nak_q        <= 1'b0;
            err_q        <= 1'b0;
            scan_start_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            ack_q        <= ack_d;
            nak_q        <= nak_d;
            err_q        <= err_d;
            scan_start_q <= scan_d;
            if (clr_d) begin
                cand_q <= '0;
                vote_q <= '0;
            end else if (cnt_en) begin
                for (int unsigned i = 0; i < NUM_CAND; i++) begin
                    if (vb_rise[i]) cand_q[i*CNT_W +: CNT_W] <= cand_q[i*CNT_W +: CNT_W] + 1'b1;
                end
                vote_q <= vote_q + 1'b1;
            end
        end
    end

    // Start is registered one cycle after RESULT entry, so the scan's
    // NUM_CAND visits complete NUM_CAND+1 cycles after entry.
    vm_winner_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_scan (
        .clk    (clk_100MHz),
        .reset  (reset),
        .clear  (clr_d),
        .start  (scan_start_q),
        .counts (cand_q),
        .winner (winner),
        .tie    (tie),
        .valid  (result_valid)
    );

    assign state      = st_q;
    assign enable_led = (st_q == ST_OPEN) || (st_q == ST_ARMED);
    assign cand_count = cand_q;
    assign vote_count = vote_q;
    assign vote_ack   = ack_q;
    assign vote_nak   = nak_q;
    assign code_err   = err_q;

endmodule
